iq_read_stage: RTL and testbench
================================

Name: iq_read_stage

Overview:
Consumer end of the ID→IR instruction queue. Each cycle it pops up to two in-order instructions from the queue head and registers them into a two-slot output stage for rename.
- Slot 1 is held back when it reads the destination register written by slot 0 (same-cycle RAW split).
- Downstream stall and pipeline flush are handled here.
- Sits between the instruction queue and the rename logic in the IR stage.

Parameters:
DATA_W, 64, width of opaque instruction payload per slot
REG_W, 5, architectural register index width
CNT_W, 32, width of performance counters
DEP_SPLIT_EN, 1, 1 = enable slot-1 RAW split; 0 = never split on dependency

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  discard registered instructions, suppress pops this cycle
stall_i  in  1  downstream cannot accept the current output pair
iq_valid_i  in  2  bit i = queue holds an entry at head+i (bit1 implies bit0)
iq_data_i  in  2×DATA_W  payload at head+i
iq_we_i  in  2  entry i writes a register
iq_rd_i  in  2×REG_W  destination register of entry i
iq_rs1_i  in  2×REG_W  source 1 of entry i
iq_rs2_i  in  2×REG_W  source 2 of entry i
iq_read_o  out  2  pop entry i this cycle (combinational)
valid_o  out  2  registered output slot valid
data_o  out  2×DATA_W  registered output payload
split_cnt_o  out  CNT_W  count of pairs split by RAW dependency
bubble_cnt_o  out  CNT_W  count of cycles the stage advanced with nothing to take

Behaviour:
- Reset (rst_i=1 at clock edge): valid_o=2'b00, data_o=0, split_cnt_o=0, bubble_cnt_o=0. iq_read_o=0 while rst_i=1. Reset overrides flush_i and stall_i.
- advance = ~stall_i | (valid_o == 2'b00). When the outputs are empty, stall_i is ignored.
- dep = DEP_SPLIT_EN & iq_we_i[0] & (iq_rd_i[0] != 0) & ((iq_rs1_i[1] == iq_rd_i[0]) | (iq_rs2_i[1] == iq_rd_i[0])).
- take0 = advance & ~flush_i & ~rst_i & iq_valid_i[0].
- take1 = take0 & iq_valid_i[1] & ~dep.
- iq_read_o = {take1, take0}. In-order popping: iq_read_o=2'b10 is never driven.
- Clock edge, no reset:
  - flush_i: valid_o←00. data_o holds its value (don't-care).
  - else if advance: valid_o←{take1, take0}; data_o[i]←iq_data_i[i] for each taken slot; an untaken slot's data is don't-care.
  - else (stalled with valid outputs): valid_o and data_o hold.
- Latency: an instruction popped in cycle N appears on valid_o/data_o in cycle N+1.
- Output invariant: valid_o=2'b10 never occurs.
- Counters (clock edge, no reset, no flush, advance=1):
  - split_cnt_o +1 when iq_valid_i==2'b11 and dep=1.
  - bubble_cnt_o +1 when iq_valid_i[0]=0.
  - Both saturate at 2^CNT_W−1 (no wrap).
- Edge cases:
  - Simultaneous flush_i and stall_i: flush wins.
  - rd=x0 never creates a dependency.
  - Slot 1 writing a register read by slot 0 (WAR) is not a dependency.
  - Reset asserted mid-stall clears everything on the next edge; the first pop is possible in the first cycle with rst_i=0.

Test Plan:
1. Reset then idle: rst_i=1 for 2 cycles, iq_valid_i=11 → iq_read_o=00 during reset. After the first edge: valid_o=00, both counters 0.
2. Dual pop, no dependency: iq_valid_i=11, rd0=5, rs1_1=6, rs2_1=7, iq_we_i=11, stall_i=0 → iq_read_o=11 same cycle. Next cycle valid_o=11, data_o equals the inputs.
3. RAW split: rd0=5, iq_we_i[0]=1, rs2_1=5 → iq_read_o=01, valid_o=01 next cycle, split_cnt_o=1. Repeat with rd0=0 → iq_read_o=11, counter unchanged. With DEP_SPLIT_EN=0 → iq_read_o=11.
4. Stall hold: valid_o=11, stall_i=1 for 3 cycles, iq_valid_i=11 → iq_read_o=00 all 3 cycles, outputs unchanged. Release stall → pop resumes the same cycle.
5. Flush priority: valid_o=11, flush_i=1 and stall_i=1, iq_valid_i=11 → iq_read_o=00, valid_o=00 next cycle, counters unchanged.
6. Bubble/saturation: CNT_W=2, iq_valid_i=00, stall_i=0 for 5 cycles → bubble_cnt_o = 1,2,3,3,3.

Source files
------------

// File: rtl/iq_read_stage.sv
// IR-stage consumer of the instruction queue: pops up to two in-order entries
// per cycle into a registered two-slot output, splitting a same-cycle RAW pair.
module iq_read_stage #(
  parameter int DATA_W       = 64,
  parameter int REG_W        = 5,
  parameter int CNT_W        = 32,
  parameter int DEP_SPLIT_EN = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                stall_i,
  input  logic [1:0]          iq_valid_i,
  input  logic [2*DATA_W-1:0] iq_data_i,
  input  logic [1:0]          iq_we_i,
  input  logic [2*REG_W-1:0]  iq_rd_i,
  input  logic [2*REG_W-1:0]  iq_rs1_i,
  input  logic [2*REG_W-1:0]  iq_rs2_i,
  output logic [1:0]          iq_read_o,
  output logic [1:0]          valid_o,
  output logic [2*DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]    split_cnt_o,
  output logic [CNT_W-1:0]    bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic             DepEn  = (DEP_SPLIT_EN != 0);

  logic [1:0]          valid_q, valid_d;
  logic [2*DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]    split_q, split_d;
  logic [CNT_W-1:0]    bubble_q, bubble_d;

  logic [REG_W-1:0] rd0, rs1Slot1, rs2Slot1;
  logic             advance, dep, take0, take1;

  assign rd0      = iq_rd_i[REG_W-1:0];
  assign rs1Slot1 = iq_rs1_i[2*REG_W-1:REG_W];
  assign rs2Slot1 = iq_rs2_i[2*REG_W-1:REG_W];

  // An empty output stage can always refill, so stall only matters when holding data.
  assign advance = ~stall_i | (valid_q == 2'b00);
  assign dep     = DepEn & iq_we_i[0] & (rd0 != '0) &
                   ((rs1Slot1 == rd0) | (rs2Slot1 == rd0));
  assign take0   = advance & ~flush_i & ~rst_i & iq_valid_i[0];
  assign take1   = take0 & iq_valid_i[1] & ~dep;

  assign iq_read_o = {take1, take0};

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    split_d  = split_q;
    bubble_d = bubble_q;
    if (flush_i) begin
      valid_d = 2'b00;
    end else if (advance) begin
      valid_d = {take1, take0};
      if (take0) data_d[DATA_W-1:0]        = iq_data_i[DATA_W-1:0];
      if (take1) data_d[2*DATA_W-1:DATA_W] = iq_data_i[2*DATA_W-1:DATA_W];
      // Counters saturate rather than wrap so long runs stay meaningful.
      if ((iq_valid_i == 2'b11) && dep && (split_q != CntMax))
        split_d = split_q + CNT_W'(1);
      if (!iq_valid_i[0] && (bubble_q != CntMax))
        bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 2'b00;
      data_q   <= '0;
      split_q  <= '0;
      bubble_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      split_q  <= split_d;
      bubble_q <= bubble_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign split_cnt_o  = split_q;
  assign bubble_cnt_o = bubble_q;

endmodule

// File: tb/tb_iq_read_stage.sv
// Scoreboard bench for iq_read_stage: stimulus pushes expected output pairs,
// a monitor pops and compares them when the stage presents new outputs.
module tb_iq_read_stage;

  localparam int DW = 64;
  localparam int RW = 5;

  typedef struct {
    logic [1:0]    v;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } expT;

  logic            clk_i = 1'b0;
  logic            rst_i, flush_i, stall_i;
  logic [1:0]      iq_valid_i, iq_we_i;
  logic [2*DW-1:0] iq_data_i;
  logic [2*RW-1:0] iq_rd_i, iq_rs1_i, iq_rs2_i;

  logic [1:0]      iq_read_o, valid_o;
  logic [2*DW-1:0] data_o;
  logic [31:0]     split_cnt_o, bubble_cnt_o;

  logic [1:0]      readNd;
  logic [1:0]      validNd;
  logic [2*DW-1:0] dataNd;
  logic [1:0]      splitNd, bubbleNd;

  expT expQ[$];
  int  checkCount = 0;
  int  passCount  = 0;

  always #5 clk_i = ~clk_i;

  iq_read_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(32), .DEP_SPLIT_EN(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
    .iq_valid_i(iq_valid_i), .iq_data_i(iq_data_i), .iq_we_i(iq_we_i),
    .iq_rd_i(iq_rd_i), .iq_rs1_i(iq_rs1_i), .iq_rs2_i(iq_rs2_i),
    .iq_read_o(iq_read_o), .valid_o(valid_o), .data_o(data_o),
    .split_cnt_o(split_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // Narrow-counter, no-split variant sharing the same inputs.
  iq_read_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(2), .DEP_SPLIT_EN(0)) dutNd (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
    .iq_valid_i(iq_valid_i), .iq_data_i(iq_data_i), .iq_we_i(iq_we_i),
    .iq_rd_i(iq_rd_i), .iq_rs1_i(iq_rs1_i), .iq_rs2_i(iq_rs2_i),
    .iq_read_o(readNd), .valid_o(validNd), .data_o(dataNd),
    .split_cnt_o(splitNd), .bubble_cnt_o(bubbleNd)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Called at a falling edge: drives one cycle of inputs, checks the pop, then advances.
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] we,
                               input logic [RW-1:0] rd0, input logic [RW-1:0] rd1,
                               input logic [RW-1:0] rs10, input logic [RW-1:0] rs20,
                               input logic [RW-1:0] rs11, input logic [RW-1:0] rs21,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic stall, input logic flush,
                               input logic [1:0] expRead, input string name);
    expT e;
    iq_valid_i = v;
    iq_we_i    = we;
    iq_rd_i    = {rd1, rd0};
    iq_rs1_i   = {rs11, rs10};
    iq_rs2_i   = {rs21, rs20};
    iq_data_i  = {d1, d0};
    stall_i    = stall;
    flush_i    = flush;
    #1;
    checkOutput({name, "_read"}, 128'(iq_read_o), 128'(expRead));
    if (expRead != 2'b00) begin
      e.v  = expRead;
      e.d0 = d0;
      e.d1 = d1;
      expQ.push_back(e);
    end
    @(negedge clk_i);
  endtask

  // Monitor: whenever the stage popped at a rising edge, the new pair is checked.
  initial begin
    logic [1:0] popped;
    expT e;
    forever begin
      @(posedge clk_i);
      popped = iq_read_o;
      @(negedge clk_i);
      if (popped != 2'b00) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL mon_unexpected: got valid 0x%0h expected no output", valid_o);
        end else begin
          e = expQ.pop_front();
          checkOutput("mon_valid", 128'(valid_o), 128'(e.v));
          if (e.v[0]) checkOutput("mon_data0", 128'(data_o[DW-1:0]), 128'(e.d0));
          if (e.v[1]) checkOutput("mon_data1", 128'(data_o[2*DW-1:DW]), 128'(e.d1));
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    iq_valid_i = 2'b11; iq_we_i = 2'b11; iq_data_i = '0;
    iq_rd_i = '0; iq_rs1_i = '0; iq_rs2_i = '0;
    #1;
    checkOutput("rst_read_a", 128'(iq_read_o), 128'(2'b00));
    @(negedge clk_i);
    checkOutput("rst_read_b", 128'(iq_read_o), 128'(2'b00));
    checkOutput("rst_valid", 128'(valid_o), 128'(2'b00));
    checkOutput("rst_split", 128'(split_cnt_o), 128'(0));
    checkOutput("rst_bubble", 128'(bubble_cnt_o), 128'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    applyStimulus(2'b11, 2'b11, 5'd5, 5'd9, 5'd1, 5'd2, 5'd6, 5'd7,
                  64'hA0A0_0000_0000_0001, 64'hB0B0_0000_0000_0002, 1'b0, 1'b0, 2'b11, "dual");

    applyStimulus(2'b11, 2'b11, 5'd5, 5'd9, 5'd1, 5'd2, 5'd8, 5'd5,
                  64'hC0C0_0000_0000_0003, 64'hD0D0_0000_0000_0004, 1'b0, 1'b0, 2'b01, "raw");
    checkOutput("split_1", 128'(split_cnt_o), 128'(1));

    // Same hazard pattern on the non-splitting instance pops both.
    iq_valid_i = 2'b11; iq_we_i = 2'b01; iq_rd_i = {5'd9, 5'd5};
    iq_rs1_i = {5'd5, 5'd1}; iq_rs2_i = {5'd3, 5'd2}; stall_i = 1'b0; flush_i = 1'b0;
    #1;
    checkOutput("nodep_read", 128'(readNd), 128'(2'b11));
    iq_valid_i = 2'b00;
    @(negedge clk_i);
    checkOutput("idle_valid", 128'(valid_o), 128'(2'b00));

    applyStimulus(2'b11, 2'b11, 5'd0, 5'd9, 5'd1, 5'd2, 5'd0, 5'd0,
                  64'h1111_0000_0000_0005, 64'h2222_0000_0000_0006, 1'b0, 1'b0, 2'b11, "rd_x0");
    checkOutput("split_x0", 128'(split_cnt_o), 128'(1));

    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b11, 2'b11, 5'd3, 5'd4, 5'd1, 5'd2, 5'd6, 5'd7,
                    64'hDEAD, 64'hBEEF, 1'b1, 1'b0, 2'b00, "stall");
      checkOutput("stall_valid", 128'(valid_o), 128'(2'b11));
      checkOutput("stall_data", 128'(data_o), {64'h2222_0000_0000_0006, 64'h1111_0000_0000_0005});
    end
    applyStimulus(2'b11, 2'b11, 5'd3, 5'd4, 5'd1, 5'd2, 5'd6, 5'd7,
                  64'h3333_0000_0000_0007, 64'h4444_0000_0000_0008, 1'b0, 1'b0, 2'b11, "unstall");

    applyStimulus(2'b11, 2'b11, 5'd3, 5'd4, 5'd1, 5'd2, 5'd6, 5'd7,
                  64'hDEAD, 64'hBEEF, 1'b1, 1'b1, 2'b00, "flush");
    checkOutput("flush_valid", 128'(valid_o), 128'(2'b00));
    checkOutput("flush_split", 128'(split_cnt_o), 128'(1));
    checkOutput("flush_bubble", 128'(bubble_cnt_o), 128'(1));

    applyStimulus(2'b11, 2'b11, 5'd3, 5'd5, 5'd5, 5'd2, 5'd6, 5'd7,
                  64'h5555_0000_0000_0009, 64'h6666_0000_0000_000A, 1'b1, 1'b0, 2'b11, "war_empty_stall");
    applyStimulus(2'b11, 2'b10, 5'd5, 5'd9, 5'd1, 5'd2, 5'd5, 5'd5,
                  64'h7777_0000_0000_000B, 64'h8888_0000_0000_000C, 1'b0, 1'b0, 2'b11, "no_we0");
    applyStimulus(2'b01, 2'b11, 5'd5, 5'd9, 5'd1, 5'd2, 5'd5, 5'd5,
                  64'h9999_0000_0000_000D, 64'hAAAA, 1'b0, 1'b0, 2'b01, "single");
    checkOutput("split_final", 128'(split_cnt_o), 128'(1));

    rst_i = 1'b1; iq_valid_i = 2'b00;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                    64'h0, 64'h0, 1'b0, 1'b0, 2'b00, "bubble");
      checkOutput("bubble_sat", 128'(bubbleNd), 128'((i > 3) ? 3 : i));
      checkOutput("bubble_wide", 128'(bubble_cnt_o), 128'(i));
    end

    checkOutput("queue_drained", 128'(expQ.size()), 128'(0));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
